fsm_seq_monitor: RTL and testbench

//  Downstream checker for the N-state code FSM: samples its 3-bit state-code output y every

---
 rtl/fsm_seq_pkg.sv | 16 +
 rtl/fsm_seq_monitor_sat_counter.sv | 19 +
 rtl/fsm_seq_monitor.sv | 136 +++++++++++++
 tb/tb_fsm_seq_monitor.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared types and helpers for the state-code sequence monitor.
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Expected successor of prev in the cyclic sequence 0..num_states-1.
    function automatic int unsigned next_code(input int unsigned prev, input int unsigned num_states);
        return (prev + 1 >= num_states) ? 0 : prev + 1;
    endfunction

endpackage

// File: rtl/fsm_seq_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clock) begin
        if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fsm_seq_monitor.sv
// Checks a state-code stream follows 0,1,..,NUM_STATES-1,0,.. with bounded stalls.
// Optional per-code visit histogram enabled by defining FSM_SEQ_MON_HIST_EN.
module fsm_seq_monitor
    import fsm_seq_pkg::*;
#(
    parameter int unsigned W          = 3,
    parameter int unsigned NUM_STATES = 5,
    parameter int unsigned CYC_W      = 8,
    parameter int unsigned RUN_CYCLES = 20,
    parameter int unsigned STALL_MAX  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [W-1:0]     y,
    output logic             locked,
    output logic             done,
    output logic             err,
    output logic [W-1:0]     err_code,
    output logic [CYC_W-1:0] err_cycle,
    output logic [CYC_W-1:0] cycles,
    output logic [CYC_W-1:0] wraps
`ifdef FSM_SEQ_MON_HIST_EN
    ,
    output logic [NUM_STATES*CYC_W-1:0] hist
`endif
);

    localparam int unsigned STALL_W = $clog2(STALL_MAX + 2);

    state_t             state;
    logic [W-1:0]       prev;
    logic [STALL_W-1:0] stall;

    logic [W-1:0] exp_code;
    logic         legal;
    logic         stall_full;
    logic         done_next;
    logic         accept;
    logic         go_error;
    logic         is_stall;
    logic         is_wrap;

    assign exp_code   = W'(next_code(32'(prev), NUM_STATES));
    assign legal      = (32'(y) < NUM_STATES);
    assign stall_full = ((32'(stall) + 32'd1) > STALL_MAX);
    assign done_next  = done || (cycles == CYC_W'(RUN_CYCLES));

    // Classify the current sample against the tracked sequence.
    always_comb begin
        accept   = 1'b0;
        go_error = 1'b0;
        is_stall = 1'b0;
        is_wrap  = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (legal) accept = 1'b1;
                    else       go_error = 1'b1;
                end
                TRACK: begin
                    if (y == exp_code) begin
                        accept  = 1'b1;
                        is_wrap = (y == '0);
                    end else if ((y == prev) && !stall_full) begin
                        accept   = 1'b1;
                        is_stall = 1'b1;
                    end else begin
                        go_error = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            prev      <= '0;
            stall     <= '0;
            locked    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
            err_cycle <= '0;
        end else begin
            if (cycles == CYC_W'(RUN_CYCLES)) done <= 1'b1;
            // Error wins over a same-edge done trigger; ERROR is terminal so this latches once.
            if (go_error) begin
                state     <= ERROR;
                locked    <= 1'b0;
                err       <= 1'b1;
                err_code  <= y;
                err_cycle <= cycles;
            end else begin
                if (accept) begin
                    prev  <= y;
                    stall <= is_stall ? stall + STALL_W'(1) : '0;
                end
                if ((state == IDLE) && accept) begin
                    state  <= TRACK;
                    locked <= 1'b1;
                end else if ((state == TRACK) && done_next) begin
                    state <= DONE;
                end
            end
        end
    end

    sat_counter #(.WIDTH(CYC_W)) u_cycles (
        .clock (clock),
        .clr   (reset),
        .inc   (1'b1),
        .value (cycles)
    );

    sat_counter #(.WIDTH(CYC_W)) u_wraps (
        .clock (clock),
        .clr   (reset),
        .inc   (is_wrap),
        .value (wraps)
    );

`ifdef FSM_SEQ_MON_HIST_EN
    for (genvar k = 0; k < int'(NUM_STATES); k++) begin : g_hist
        sat_counter #(.WIDTH(CYC_W)) u_hist (
            .clock (clock),
            .clr   (reset),
            .inc   (accept && (y == W'(k))),
            .value (hist[k*CYC_W +: CYC_W])
        );
    end
`endif

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Directed self-checking bench for fsm_seq_monitor (default parameters).
module tb_fsm_seq_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic [2:0] y     = '0;
    logic       locked, done, err;
    logic [2:0] err_code;
    logic [7:0] err_cycle, cycles, wraps;
`ifdef FSM_SEQ_MON_HIST_EN
    logic [39:0] hist;
`endif

    int tests = 0;
    int fails = 0;

    fsm_seq_monitor dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .y         (y),
        .locked    (locked),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .err_cycle (err_cycle),
        .cycles    (cycles),
        .wraps     (wraps)
`ifdef FSM_SEQ_MON_HIST_EN
        ,
        .hist      (hist)
`endif
    );

    always #5 clock = ~clock;

    task automatic step(input logic e, input logic [2:0] v);
        en = e;
        y  = v;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 3'd0);
        step(1'b0, 3'd0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (cycles !== 8'd0)    begin fails++; $display("FAIL reset_cycles got %0d want 0", cycles); end
        tests++; if (wraps !== 8'd0)     begin fails++; $display("FAIL reset_wraps got %0d want 0", wraps); end
        tests++; if (locked !== 1'b0)    begin fails++; $display("FAIL reset_locked got %b want 0", locked); end
        tests++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (err !== 1'b0)       begin fails++; $display("FAIL reset_err got %b want 0", err); end
        tests++; if (err_code !== 3'd0)  begin fails++; $display("FAIL reset_err_code got %0d want 0", err_code); end
        tests++; if (err_cycle !== 8'd0) begin fails++; $display("FAIL reset_err_cycle got %0d want 0", err_cycle); end
    endtask

    // Edge i (cycles==i before it) carries code (i-1)%5 for i=1..20; en low on edge 0.
    task automatic test_sequence();
        do_reset();
        step(1'b0, 3'd0);
        for (int i = 1; i <= 16; i++) step(1'b1, 3'((i - 1) % 5));
        tests++; if (wraps !== 8'd3)   begin fails++; $display("FAIL seq_wraps16 got %0d want 3", wraps); end
        tests++; if (err !== 1'b0)     begin fails++; $display("FAIL seq_err got %b want 0", err); end
        tests++; if (locked !== 1'b1)  begin fails++; $display("FAIL seq_locked got %b want 1", locked); end
        tests++; if (cycles !== 8'd17) begin fails++; $display("FAIL seq_cycles got %0d want 17", cycles); end
        for (int i = 17; i <= 19; i++) step(1'b1, 3'((i - 1) % 5));
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL seq_done_early got %b want 0", done); end
        tests++; if (cycles !== 8'd20) begin fails++; $display("FAIL seq_cycles20 got %0d want 20", cycles); end
        step(1'b1, 3'd4);
        tests++; if (done !== 1'b1)    begin fails++; $display("FAIL seq_done got %b want 1", done); end
        // DONE: a wrap-looking sample and an illegal code must both be ignored.
        step(1'b1, 3'd0);
        step(1'b1, 3'd7);
        tests++; if (wraps !== 8'd3)   begin fails++; $display("FAIL done_wraps_frozen got %0d want 3", wraps); end
        tests++; if (err !== 1'b0)     begin fails++; $display("FAIL done_err got %b want 0", err); end
        tests++; if (locked !== 1'b1)  begin fails++; $display("FAIL done_locked got %b want 1", locked); end
        tests++; if (done !== 1'b1)    begin fails++; $display("FAIL done_sticky got %b want 1", done); end
`ifdef FSM_SEQ_MON_HIST_EN
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (hist[k*8 +: 8] !== 8'd4) begin fails++; $display("FAIL hist_%0d got %0d want 4", k, hist[k*8 +: 8]); end
        end
`endif
    endtask

    task automatic test_stall();
        do_reset();
        step(1'b1, 3'd0); step(1'b1, 3'd1); step(1'b1, 3'd1); step(1'b1, 3'd1); step(1'b1, 3'd2);
        tests++; if (err !== 1'b0)    begin fails++; $display("FAIL stall_ok_err got %b want 0", err); end
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL stall_ok_locked got %b want 1", locked); end
        do_reset();
        step(1'b1, 3'd0); step(1'b1, 3'd1); step(1'b1, 3'd1); step(1'b1, 3'd1);
        tests++; if (err !== 1'b0)     begin fails++; $display("FAIL stall_max_err got %b want 0", err); end
        step(1'b1, 3'd1);
        tests++; if (err !== 1'b1)     begin fails++; $display("FAIL stall_over_err got %b want 1", err); end
        tests++; if (err_code !== 3'd1) begin fails++; $display("FAIL stall_over_code got %0d want 1", err_code); end
        tests++; if (err_cycle !== 8'd4) begin fails++; $display("FAIL stall_over_cycle got %0d want 4", err_cycle); end
        tests++; if (locked !== 1'b0)  begin fails++; $display("FAIL stall_over_locked got %b want 0", locked); end
    endtask

    task automatic test_jump();
        do_reset();
        step(1'b1, 3'd0); step(1'b1, 3'd1);
        tests++; if (locked !== 1'b1)    begin fails++; $display("FAIL jump_locked_pre got %b want 1", locked); end
        step(1'b1, 3'd3);
        tests++; if (err !== 1'b1)       begin fails++; $display("FAIL jump_err got %b want 1", err); end
        tests++; if (err_code !== 3'd3)  begin fails++; $display("FAIL jump_code got %0d want 3", err_code); end
        tests++; if (err_cycle !== 8'd2) begin fails++; $display("FAIL jump_cycle got %0d want 2", err_cycle); end
        tests++; if (locked !== 1'b0)    begin fails++; $display("FAIL jump_locked got %b want 0", locked); end
    endtask

    task automatic test_bad_first();
        do_reset();
        step(1'b1, 3'd6);
        tests++; if (err !== 1'b1)       begin fails++; $display("FAIL first_err got %b want 1", err); end
        tests++; if (err_code !== 3'd6)  begin fails++; $display("FAIL first_code got %0d want 6", err_code); end
        tests++; if (err_cycle !== 8'd0) begin fails++; $display("FAIL first_cycle got %0d want 0", err_cycle); end
        step(1'b1, 3'd0); step(1'b1, 3'd2);
        tests++; if (locked !== 1'b0)    begin fails++; $display("FAIL first_locked got %b want 0", locked); end
        tests++; if (err_code !== 3'd6)  begin fails++; $display("FAIL first_code_held got %0d want 6", err_code); end
    endtask

    // en=0 samples of the current code must not count as stalls.
    task automatic test_enable_gap();
        do_reset();
        step(1'b1, 3'd0); step(1'b0, 3'd6); step(1'b1, 3'd1); step(1'b0, 3'd1); step(1'b0, 3'd1);
        step(1'b1, 3'd1); step(1'b1, 3'd1); step(1'b0, 3'd7); step(1'b1, 3'd2);
        tests++; if (err !== 1'b0)    begin fails++; $display("FAIL gap_err got %b want 0", err); end
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL gap_locked got %b want 1", locked); end
        tests++; if (cycles !== 8'd9) begin fails++; $display("FAIL gap_cycles got %0d want 9", cycles); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 3'(i % 5));
        tests++; if (cycles !== 8'd10) begin fails++; $display("FAIL mid_cycles_pre got %0d want 10", cycles); end
        tests++; if (wraps !== 8'd1)   begin fails++; $display("FAIL mid_wraps_pre got %0d want 1", wraps); end
        reset = 1'b1;
        step(1'b1, 3'd0);
        reset = 1'b0;
        tests++; if (cycles !== 8'd0)  begin fails++; $display("FAIL mid_cycles got %0d want 0", cycles); end
        tests++; if (wraps !== 8'd0)   begin fails++; $display("FAIL mid_wraps got %0d want 0", wraps); end
        tests++; if (locked !== 1'b0)  begin fails++; $display("FAIL mid_locked got %b want 0", locked); end
`ifdef FSM_SEQ_MON_HIST_EN
        tests++; if (hist !== 40'd0)   begin fails++; $display("FAIL mid_hist got %h want 0", hist); end
`endif
        step(1'b1, 3'd3);
        tests++; if (locked !== 1'b1)  begin fails++; $display("FAIL relock got %b want 1", locked); end
        step(1'b1, 3'd4); step(1'b1, 3'd0);
        tests++; if (wraps !== 8'd1)   begin fails++; $display("FAIL relock_wraps got %0d want 1", wraps); end
        tests++; if (err !== 1'b0)     begin fails++; $display("FAIL relock_err got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_jump();
        test_bad_first();
        test_enable_gap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
